// File: rtl/ll_tx_pkg.sv
// Shared definitions for the LocalLink transmit framer.
// Optional feature macro: LL_TX_PAD_EN (pad short frames with 0x00 up to MIN_LEN).
package ll_tx_pkg;

  localparam int MIN_LEN_DEF = 60;

  // FIFO entry layout: {sod, eod, data[7:0]}
  localparam int ENTRY_W = 10;
  localparam int SOD_BIT = 9;
  localparam int EOD_BIT = 8;

`ifdef LL_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAD = 2'd2} state_t;
`else
  localparam bit PAD_EN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

endpackage

// File: rtl/ll_tx_fifo.sv
// Single-clock first-word-fall-through byte FIFO. One slot is kept free so that
// pointer equality always means empty. mark_eod_i retro-tags the most recently
// written entry as end-of-packet (used when a packet's eod byte is dropped).
module ll_tx_fifo
  import ll_tx_pkg::*;
#(
  parameter int AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic               mark_eod_i,
  input  logic               rd_en_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int DEPTH = 1 << AW;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      last_ptr;

  assign last_ptr  = wr_ptr_q - AW'(1);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = ((wr_ptr_q + AW'(1)) == rd_ptr_q);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q + (wr_en_i ? AW'(1) : AW'(0));
    rd_ptr_d = rd_ptr_q + (rd_en_i ? AW'(1) : AW'(0));
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage: normal write, or eod tag on the last written entry (never both)
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end else if (mark_eod_i) begin
      mem_q[last_ptr][EOD_BIT] <= 1'b1;
    end
  end

endmodule

// File: rtl/ll_tx_framer.sv
// Store-and-forward LocalLink transmit framer. Bytes are collected into a FIFO
// and a frame is emitted only once its eod byte has been stored. Output beats
// go through a one-entry register so data/sof/eof hold while the sink stalls.
// Optional feature macro: LL_TX_PAD_EN (pad short frames with 0x00 to MIN_LEN).
module ll_tx_framer
  import ll_tx_pkg::*;
#(
  parameter int FIFO_AW = 11,
  parameter int MIN_LEN = MIN_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_sod,
  input  logic       i_enable,
  input  logic       i_eod,
  output logic       o_full,
  output logic       o_drop,
  output logic [7:0] tx_ll_data_out,
  output logic       tx_ll_sof_out_n,
  output logic       tx_ll_eof_out_n,
  output logic       tx_ll_src_rdy_n,
  input  logic       tx_ll_dst_rdy_n,
  output logic       o_busy,
  output logic [7:0] o_pkt_cnt
);

  localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  state_t             state_q, state_d;
  logic               in_pkt_q, in_pkt_d, wrote_any_q, wrote_any_d;
  logic               drop_q;
  logic [FIFO_AW:0]   pend_q, pend_d;
  logic [10:0]        len_q, len_d, len_nxt;
  logic               out_vld_q, out_vld_d, out_sof_q, out_sof_d, out_eof_q, out_eof_d;
  logic [7:0]         out_data_q, out_data_d, cnt_q, cnt_d;
  logic               in_byte, has_bytes, drop, pkt_inc, pkt_dec;
  logic               fifo_wr, fifo_rd, fifo_mark, fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               xfer, can_ld, ld, is_short;
  logic               beat_sof, beat_eof;
  logic [7:0]         beat_data;

  ll_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (fifo_wr),
    .wr_data_i  ({~in_pkt_q, i_eod, i_data}),
    .mark_eod_i (fifo_mark),
    .rd_en_i    (fifo_rd),
    .rd_data_o  (fifo_rdata),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  // Input side: packet delimiting, overflow drop and eod recovery
  always_comb begin
    in_byte     = i_enable && (in_pkt_q || i_sod);
    o_full      = fifo_full && !fifo_rd;
    fifo_wr     = in_byte && !o_full;
    drop        = in_byte && o_full;
    has_bytes   = in_pkt_q && wrote_any_q;
    fifo_mark   = drop && i_eod && has_bytes;
    pkt_inc     = (fifo_wr && i_eod) || fifo_mark;
    pkt_dec     = fifo_rd && fifo_rdata[EOD_BIT];
    pend_d      = pend_q + (FIFO_AW+1)'(pkt_inc) - (FIFO_AW+1)'(pkt_dec);
    in_pkt_d    = in_pkt_q;
    wrote_any_d = wrote_any_q;
    if (in_byte) begin
      in_pkt_d    = !i_eod;
      wrote_any_d = !i_eod && (has_bytes || fifo_wr);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pend_q != '0) state_d = DATA;
      DATA: begin
        if (ld && fifo_rdata[EOD_BIT]) begin
`ifdef LL_TX_PAD_EN
          state_d = is_short ? PAD : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef LL_TX_PAD_EN
      PAD:  if (ld && (len_nxt == MIN_LEN_W)) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: form the next beat for the output register
  always_comb begin
    xfer      = out_vld_q && !tx_ll_dst_rdy_n;
    can_ld    = !out_vld_q || xfer;
    len_nxt   = sat_inc(len_q);
    is_short  = len_nxt < MIN_LEN_W;
    ld        = 1'b0;
    fifo_rd   = 1'b0;
    beat_data = 8'h00;
    beat_sof  = 1'b0;
    beat_eof  = 1'b0;
    case (state_q)
      DATA: begin
        if (can_ld && !fifo_empty) begin
          ld        = 1'b1;
          fifo_rd   = 1'b1;
          beat_data = fifo_rdata[7:0];
          beat_sof  = fifo_rdata[SOD_BIT] || (len_q == 11'd0);
          beat_eof  = fifo_rdata[EOD_BIT] && !(PAD_EN && is_short);
        end
      end
`ifdef LL_TX_PAD_EN
      PAD: begin
        if (can_ld) begin
          ld       = 1'b1;
          beat_eof = (len_nxt == MIN_LEN_W);
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath next state: length, output register, frame counter
  always_comb begin
    len_d      = (state_q == IDLE) ? 11'd0 : (ld ? len_nxt : len_q);
    out_vld_d  = out_vld_q;
    out_sof_d  = out_sof_q;
    out_eof_d  = out_eof_q;
    out_data_d = out_data_q;
    if (can_ld) begin
      out_vld_d = ld;
      out_sof_d = beat_sof;
      out_eof_d = beat_eof;
      if (ld) out_data_d = beat_data;
    end
    cnt_d = cnt_q + ((xfer && out_eof_q) ? 8'd1 : 8'd0);
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q    <= 1'b0;
      wrote_any_q <= 1'b0;
      drop_q      <= 1'b0;
      pend_q      <= '0;
      len_q       <= '0;
      out_vld_q   <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= 8'h00;
      cnt_q       <= 8'h00;
    end else begin
      in_pkt_q    <= in_pkt_d;
      wrote_any_q <= wrote_any_d;
      drop_q      <= drop;
      pend_q      <= pend_d;
      len_q       <= len_d;
      out_vld_q   <= out_vld_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_drop          = drop_q;
  assign tx_ll_data_out  = out_data_q;
  assign tx_ll_src_rdy_n = !out_vld_q;
  assign tx_ll_sof_out_n = !out_sof_q;
  assign tx_ll_eof_out_n = !out_eof_q;
  assign o_busy          = (state_q != IDLE) || out_vld_q;
  assign o_pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_ll_tx_framer.sv
// Directed bench for ll_tx_framer: a default-size instance and a FIFO_AW=4
// instance. Expected beats are queued when stimulus is driven and compared as
// the DUT transfers them.
module tb_ll_tx_framer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] d0_data = '0, d1_data = '0;
  logic d0_sod = 0, d0_en = 0, d0_eod = 0, d0_dst_n = 1;
  logic d1_sod = 0, d1_en = 0, d1_eod = 0, d1_dst_n = 1;
  logic d0_full, d0_drop, d0_sof_n, d0_eof_n, d0_src_n, d0_busy;
  logic d1_full, d1_drop, d1_sof_n, d1_eof_n, d1_src_n, d1_busy;
  logic [7:0] d0_dout, d0_cnt, d1_dout, d1_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int beats0 = 0, beats1 = 0;
  bit stall0 = 0, stall1 = 0;
  logic [10:0] held0 = '0, held1 = '0;

  ll_tx_framer dut0 (
    .clk(clk), .rst(rst), .i_data(d0_data), .i_sod(d0_sod), .i_enable(d0_en),
    .i_eod(d0_eod), .o_full(d0_full), .o_drop(d0_drop), .tx_ll_data_out(d0_dout),
    .tx_ll_sof_out_n(d0_sof_n), .tx_ll_eof_out_n(d0_eof_n),
    .tx_ll_src_rdy_n(d0_src_n), .tx_ll_dst_rdy_n(d0_dst_n),
    .o_busy(d0_busy), .o_pkt_cnt(d0_cnt)
  );

  ll_tx_framer #(.FIFO_AW(4)) dut1 (
    .clk(clk), .rst(rst), .i_data(d1_data), .i_sod(d1_sod), .i_enable(d1_en),
    .i_eod(d1_eod), .o_full(d1_full), .o_drop(d1_drop), .tx_ll_data_out(d1_dout),
    .tx_ll_sof_out_n(d1_sof_n), .tx_ll_eof_out_n(d1_eof_n),
    .tx_ll_src_rdy_n(d1_src_n), .tx_ll_dst_rdy_n(d1_dst_n),
    .o_busy(d1_busy), .o_pkt_cnt(d1_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beats {data, sof_n, eof_n}; short frames grow to 60 when padding is built in
  task automatic push_frame(input int which, input int len, input logic [7:0] base);
    int n = len;
    logic [7:0] d;
`ifdef LL_TX_PAD_EN
    if (n < 60) n = 60;
`endif
    for (int i = 0; i < n; i++) begin
      d = (i < len) ? base + 8'(i) : 8'h00;
      if (which == 0) q0.push_back({d, i != 0, i != n - 1});
      else            q1.push_back({d, i != 0, i != n - 1});
    end
  endtask

  task automatic drive_byte(input int which, input logic [7:0] d, input logic sod, input logic eod);
    if (which == 0) begin d0_data = d; d0_sod = sod; d0_eod = eod; d0_en = 1; end
    else            begin d1_data = d; d1_sod = sod; d1_eod = eod; d1_en = 1; end
    @(posedge clk); #1;
    d0_en = 0; d1_en = 0;
  endtask

  task automatic send_pkt(input int which, input int len, input logic [7:0] base);
    push_frame(which, len, base);
    for (int i = 0; i < len; i++) drive_byte(which, base + 8'(i), i == 0, i == len - 1);
  endtask

  task automatic wait_idle(input int which, input int budget);
    int n = 0;
    while (n < budget && ((which == 0) ? (q0.size() != 0 || d0_busy) : (q1.size() != 0 || d1_busy))) begin
      @(posedge clk); #1;
      n++;
    end
    if (which == 0) chk("d0_drain", {30'd0, q0.size() != 0, d0_busy}, 32'd0);
    else            chk("d1_drain", {30'd0, q1.size() != 0, d1_busy}, 32'd0);
  endtask

  // Transfer scoreboard and stall-stability monitor, instance 0
  always @(negedge clk) begin
    if (!rst && !d0_src_n && !d0_dst_n) begin
      beats0 <= beats0 + 1;
      if (q0.size() == 0) chk("d0_extra_beat", 32'(q0.size()), 32'd1);
      else chk("d0_beat", {22'd0, d0_dout, d0_sof_n, d0_eof_n}, {22'd0, q0.pop_front()});
    end
    if (!rst && stall0) chk("d0_stall_hold", {21'd0, d0_src_n, d0_dout, d0_sof_n, d0_eof_n}, {21'd0, held0});
    stall0 <= !rst && !d0_src_n && d0_dst_n;
    held0  <= {d0_src_n, d0_dout, d0_sof_n, d0_eof_n};
  end

  // Transfer scoreboard and stall-stability monitor, instance 1
  always @(negedge clk) begin
    if (!rst && !d1_src_n && !d1_dst_n) begin
      beats1 <= beats1 + 1;
      if (q1.size() == 0) chk("d1_extra_beat", 32'(q1.size()), 32'd1);
      else chk("d1_beat", {22'd0, d1_dout, d1_sof_n, d1_eof_n}, {22'd0, q1.pop_front()});
    end
    if (!rst && stall1) chk("d1_stall_hold", {21'd0, d1_src_n, d1_dout, d1_sof_n, d1_eof_n}, {21'd0, held1});
    stall1 <= !rst && !d1_src_n && d1_dst_n;
    held1  <= {d1_src_n, d1_dout, d1_sof_n, d1_eof_n};
  end

  initial begin
    int drops;
    int base_beats;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_src_rdy_n", 32'(d0_src_n), 32'd1);
    chk("rst_sof_n",     32'(d0_sof_n), 32'd1);
    chk("rst_eof_n",     32'(d0_eof_n), 32'd1);
    chk("rst_data",      32'(d0_dout),  32'd0);
    chk("rst_full",      32'(d0_full),  32'd0);
    chk("rst_drop",      32'(d0_drop),  32'd0);
    chk("rst_busy",      32'(d0_busy),  32'd0);
    chk("rst_pkt_cnt",   32'(d0_cnt),   32'd0);
    rst = 0;

    // 64-byte packet 0x00..0x3F with latency check on the eod write
    d0_dst_n = 0;
    push_frame(0, 64, 8'h00);
    for (int i = 0; i < 63; i++) drive_byte(0, 8'(i), i == 0, 1'b0);
    drive_byte(0, 8'h3F, 1'b0, 1'b1);
    chk("lat_n0_src_rdy_n", 32'(d0_src_n), 32'd1);
    @(posedge clk); #1;
    chk("lat_n1_src_rdy_n", 32'(d0_src_n), 32'd1);
    @(posedge clk); #1;
    chk("lat_n2_src_rdy_n", 32'(d0_src_n), 32'd0);
    chk("lat_n2_sof_n",     32'(d0_sof_n), 32'd0);
    wait_idle(0, 500);
    chk("pkt_cnt_after_64", 32'(d0_cnt), 32'd1);

    // 10-byte packet (padded to 60 beats when padding is built in)
    send_pkt(0, 10, 8'hA0);
    wait_idle(0, 500);
    chk("pkt_cnt_after_10", 32'(d0_cnt), 32'd2);

    // 64-byte packet with sink toggling every cycle
    d0_dst_n = 1;
    send_pkt(0, 64, 8'h80);
    n = 0;
    while (n < 1000 && (q0.size() != 0 || d0_busy)) begin
      d0_dst_n = ~d0_dst_n;
      @(posedge clk); #1;
      n++;
    end
    d0_dst_n = 0;
    wait_idle(0, 50);
    chk("pkt_cnt_after_toggle", 32'(d0_cnt), 32'd3);

    // Two short packets queued back to back
    d0_dst_n = 1;
    send_pkt(0, 3, 8'h30);
    send_pkt(0, 4, 8'h50);
    d0_dst_n = 0;
    wait_idle(0, 500);
    chk("pkt_cnt_after_b2b", 32'(d0_cnt), 32'd5);
    chk("drop_idle", 32'(d0_drop), 32'd0);

    // Reset in the middle of a frame
    base_beats = beats0;
    send_pkt(0, 64, 8'h00);
    n = 0;
    while (n < 500 && (beats0 - base_beats) < 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beats_before_abort", 32'(beats0 - base_beats), 32'd5);
    rst = 1;
    d0_dst_n = 1;
    @(posedge clk); #1;
    chk("abort_src_rdy_n", 32'(d0_src_n), 32'd1);
    chk("abort_busy",      32'(d0_busy),  32'd0);
    chk("abort_pkt_cnt",   32'(d0_cnt),   32'd0);
    q0.delete();
    rst = 0;
    d0_dst_n = 0;
    send_pkt(0, 8, 8'h10);
    wait_idle(0, 500);
    chk("pkt_cnt_after_abort", 32'(d0_cnt), 32'd1);

    // 256 single-byte packets: frame counter wraps
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 256; i++) send_pkt(0, 1, 8'(i));
    wait_idle(0, 20000);
    chk("pkt_cnt_wrap", 32'(d0_cnt), 32'd0);

    // Overflow on the 16-entry FIFO with the sink stalled
    d1_dst_n = 1;
    push_frame(1, 15, 8'h40);
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      drive_byte(1, 8'h40 + 8'(i), i == 0, i == 19);
      if (d1_drop) drops++;
      if (i == 13) chk("full_at_14", 32'(d1_full), 32'd0);
      if (i == 14) chk("full_at_15", 32'(d1_full), 32'd1);
    end
    @(posedge clk); #1;
    if (d1_drop) drops++;
    chk("drop_pulses", 32'(drops), 32'd5);
    d1_dst_n = 0;
    wait_idle(1, 500);
    chk("small_pkt_cnt", 32'(d1_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
